// File: rtl/mc_controller_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle RV32I control unit.
// Latency: none, plain signal bundle.
// Backpressure: none; optional memory-ready stalling is carried on a separate port.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;

    // Controller side: consumes instruction fields, drives datapath controls.
    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );

    // Datapath side: the mirror image.
    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing of a shared datapath.
// Latency: Moore outputs from the state register; lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles.
// Backpressure: with MC_MEM_READY_EN defined, FETCH/MEMREAD/MEMWRITE stall while mem_ready = 0.
module mc_controller #(
    parameter int STATE_W = 4  // must be >= 4; codes beyond the defined states behave as FETCH
) (
    input  logic clk,
    input  logic reset,
`ifdef MC_MEM_READY_EN
    input  logic mem_ready,
`endif
    mc_controller_if.master bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_EXECI    = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_JAL      = STATE_W'(9),
        S_BEQ      = STATE_W'(10)
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       mem_rdy;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic [1:0] imm_src;

`ifdef MC_MEM_READY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // State register; reset returns to FETCH, aborting whatever instruction was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls; reset forces FETCH controls with all writes off.
    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_rdy;
                pc_update  = mem_rdy;
                state_d    = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes OldPC + imm so BEQ already has its target in ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_ITYP:      state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;  // illegal op is skipped without side effects
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = mem_rdy;
                state_d   = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Unused encodings look like FETCH for one cycle, then land in a real FETCH.
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_rdy;
                pc_update  = mem_rdy;
                state_d    = S_FETCH;
            end
        endcase

        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b10;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b00;
            state_d    = S_FETCH;
        end
    end

    // ALU decoder: alu_op selects add, sub, or a funct3-driven operation.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_control = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    3'b101:  alu_control = 3'b111;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format follows the opcode alone, independent of state.
    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write    = pc_update | (branch & bus.zero);
    assign bus.adr_src     = adr_src;
    assign bus.mem_write   = mem_write;
    assign bus.ir_write    = ir_write;
    assign bus.reg_write   = reg_write;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.imm_src     = imm_src;
    assign bus.alu_control = alu_control;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: fixed vectors, reset/abort sequences and random instruction streams.
// Latency: checks every cycle of each instruction against an instruction-level reference.
// Backpressure: mem_ready stall sequences are exercised when MC_MEM_READY_EN is defined.
module tb_mc_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } outs_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         len;
        int         chk;
        outs_t      exp;
    } vec_t;

    // What the datapath is doing in a given cycle of an instruction.
    typedef enum {P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
                  P_EXEC_R, P_EXEC_I, P_WB, P_LINK, P_BRANCH} phase_e;

    logic clk = 1'b0;
    logic reset;
`ifdef MC_MEM_READY_EN
    logic mem_ready;
`endif

    mc_controller_if bus_if();

    mc_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MC_MEM_READY_EN
        .mem_ready (mem_ready),
`endif
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    phase_e plan_q[$];
    vec_t   vecs[17];

    function automatic outs_t mk(input logic pc, input logic adr, input logic mw, input logic ir,
                                 input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                 input logic [1:0] b, input logic [1:0] imm, input logic [2:0] alu);
        outs_t o;
        o = '{pc_write: pc, adr_src: adr, mem_write: mw, ir_write: ir, reg_write: rw,
              result_src: rs, alu_src_a: a, alu_src_b: b, imm_src: imm, alu_control: alu};
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.pc_write    = bus_if.pc_write;
        o.adr_src     = bus_if.adr_src;
        o.mem_write   = bus_if.mem_write;
        o.ir_write    = bus_if.ir_write;
        o.reg_write   = bus_if.reg_write;
        o.result_src  = bus_if.result_src;
        o.alu_src_a   = bus_if.alu_src_a;
        o.alu_src_b   = bus_if.alu_src_b;
        o.imm_src     = bus_if.imm_src;
        o.alu_control = bus_if.alu_control;
        return o;
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc%b adr%b mw%b ir%b rw%b rs%b a%b b%b imm%b alu%b, expected pc%b adr%b mw%b ir%b rw%b rs%b a%b b%b imm%b alu%b",
                     name, act.pc_write, act.adr_src, act.mem_write, act.ir_write, act.reg_write,
                     act.result_src, act.alu_src_a, act.alu_src_b, act.imm_src, act.alu_control,
                     exp.pc_write, exp.adr_src, exp.mem_write, exp.ir_write, exp.reg_write,
                     exp.result_src, exp.alu_src_a, exp.alu_src_b, exp.imm_src, exp.alu_control);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] imm_for(input logic [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_for(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;  // sub only for R-type with funct7b5
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            3'b101:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic void build_plan(input logic [6:0] op);
        plan_q.delete();
        plan_q.push_back(P_FETCH);
        plan_q.push_back(P_DECODE);
        case (op)
            OP_LW:   begin plan_q.push_back(P_ADDR); plan_q.push_back(P_LOAD); plan_q.push_back(P_LOADWB); end
            OP_SW:   begin plan_q.push_back(P_ADDR); plan_q.push_back(P_STORE); end
            OP_RTYP: begin plan_q.push_back(P_EXEC_R); plan_q.push_back(P_WB); end
            OP_ITYP: begin plan_q.push_back(P_EXEC_I); plan_q.push_back(P_WB); end
            OP_JAL:  begin plan_q.push_back(P_LINK); plan_q.push_back(P_WB); end
            OP_BEQ:  plan_q.push_back(P_BRANCH);
            default: ;
        endcase
    endfunction

    function automatic outs_t model(input phase_e p, input logic [6:0] op, input logic [2:0] f3,
                                    input logic f7, input logic z);
        outs_t e;
        e = '0;
        e.imm_src = imm_for(op);
        case (p)
            P_FETCH:  begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
            P_DECODE: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            P_ADDR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            P_LOAD:   e.adr_src = 1'b1;
            P_LOADWB: begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            P_STORE:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            P_EXEC_R: begin e.alu_src_a = 2'b10; e.alu_control = alu_for(op, f3, f7); end
            P_EXEC_I: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = alu_for(op, f3, f7); end
            P_WB:     e.reg_write = 1'b1;
            P_LINK:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            P_BRANCH: begin e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z; end
            default:  ;
        endcase
        return e;
    endfunction

    // Runs one complete instruction from FETCH, checking every cycle against the model.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input string tag);
        logic z;
        build_plan(op);
        bus_if.op       = op;
        bus_if.funct3   = f3;
        bus_if.funct7b5 = f7;
        foreach (plan_q[k]) begin
            z = 1'($urandom_range(0, 1));
            bus_if.zero = z;
            @(negedge clk);
            check($sformatf("%s op=%b f3=%b f7=%b cyc%0d", tag, op, f3, f7, k + 1),
                  sample(), model(plan_q[k], op, f3, f7, z));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] legal_ops [6];
        logic [6:0] rop;
        outs_t      rst_outs;

        legal_ops = '{OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_JAL, OP_BEQ};

        // Hand-derived expectations for specific cycles of specific instructions.
        vecs[0]  = '{"lw_memwb",     OP_LW,   3'b010, 1'b0, 1'b0, 5, 5, mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000)};
        vecs[1]  = '{"lw_memread",   OP_LW,   3'b010, 1'b0, 1'b0, 5, 4, mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000)};
        vecs[2]  = '{"lw_memadr",    OP_LW,   3'b010, 1'b0, 1'b0, 5, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000)};
        vecs[3]  = '{"sw_memwrite",  OP_SW,   3'b010, 1'b0, 1'b0, 4, 4, mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000)};
        vecs[4]  = '{"r_sub",        OP_RTYP, 3'b000, 1'b1, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001)};
        vecs[5]  = '{"r_add",        OP_RTYP, 3'b000, 1'b0, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000)};
        vecs[6]  = '{"r_slt",        OP_RTYP, 3'b010, 1'b1, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101)};
        vecs[7]  = '{"r_sra",        OP_RTYP, 3'b101, 1'b1, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b111)};
        vecs[8]  = '{"r_or",         OP_RTYP, 3'b110, 1'b0, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011)};
        vecs[9]  = '{"r_and",        OP_RTYP, 3'b111, 1'b0, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010)};
        vecs[10] = '{"r_f3_001_add", OP_RTYP, 3'b001, 1'b1, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000)};
        vecs[11] = '{"r_aluwb_add",  OP_RTYP, 3'b000, 1'b1, 1'b0, 4, 4, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000)};
        vecs[12] = '{"addi_f7_add",  OP_ITYP, 3'b000, 1'b1, 1'b0, 4, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000)};
        vecs[13] = '{"beq_taken",    OP_BEQ,  3'b000, 1'b0, 1'b1, 3, 3, mk(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001)};
        vecs[14] = '{"beq_not",      OP_BEQ,  3'b000, 1'b0, 1'b0, 3, 3, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001)};
        vecs[15] = '{"jal_link",     OP_JAL,  3'b000, 1'b0, 1'b0, 4, 3, mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000)};
        vecs[16] = '{"illegal_dec",  7'b0000000, 3'b000, 1'b0, 1'b0, 2, 2, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000)};

        reset           = 1'b1;
        bus_if.op       = OP_RTYP;
        bus_if.funct3   = 3'b000;
        bus_if.funct7b5 = 1'b0;
        bus_if.zero     = 1'b0;
`ifdef MC_MEM_READY_EN
        mem_ready       = 1'b1;
`endif

        // Reset held for three cycles: FETCH controls with no write enables.
        rst_outs = mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold cyc%0d", i), sample(), rst_outs);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        run_instr(OP_RTYP, 3'b000, 1'b0, "after_reset");

        // Fixed vectors.
        for (int i = 0; i < 17; i++) begin
            bus_if.op       = vecs[i].op;
            bus_if.funct3   = vecs[i].f3;
            bus_if.funct7b5 = vecs[i].f7;
            bus_if.zero     = vecs[i].zero;
            for (int c = 1; c <= vecs[i].len; c++) begin
                @(negedge clk);
                if (c == 1) check_bit({vecs[i].name, "_fetch_ir"}, bus_if.ir_write, 1'b1);
                if (c == vecs[i].chk) check(vecs[i].name, sample(), vecs[i].exp);
                @(posedge clk);
                #1;
            end
        end
        // The illegal op must have returned to FETCH after two cycles.
        run_instr(OP_ITYP, 3'b111, 1'b0, "after_illegal");

        // Reset in the middle of a load aborts it; no write issued during the reset cycle.
        build_plan(OP_LW);
        bus_if.op = OP_LW;
        bus_if.funct3 = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_lw cyc%0d", k + 1), sample(), model(plan_q[k], OP_LW, 3'b010, 1'b0, bus_if.zero));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_lw reset_cycle", sample(), rst_outs);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(OP_LW, 3'b010, 1'b0, "after_abort");

`ifdef MC_MEM_READY_EN
        // FETCH stalled two cycles: no IR/PC write until memory is ready.
        bus_if.op = 7'b0000000;
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("fetch_stall cyc%0d", k + 1), sample(), mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("fetch_stall release", sample(), mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fetch_stall decode", sample(), mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        @(posedge clk);
        #1;
        // Store held one cycle in MEMWRITE.
        bus_if.op = OP_SW;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("store_stall hold", sample(), mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000));
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("store_stall release", sample(), mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000));
        @(posedge clk);
        #1;
        run_instr(OP_BEQ, 3'b000, 1'b0, "after_store_stall");
`endif

        // Random instruction stream, including arbitrary (mostly illegal) opcodes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 6) == 6) rop = 7'($urandom_range(0, 127));
            else                           rop = legal_ops[$urandom_range(0, 5)];
            run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
